// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Included by if_stage and its instruction queue.
package if_stage_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned ILEN_BYTES = 4;

    localparam logic [XLEN-1:0] PC_START = 64'h8000_0000;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [XLEN-1:0]   addr_t;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_WAIT  = 2'd1,
        IF_DROP  = 2'd2
    } if_state_e;

    // Bundle handed to decode, 96 bits wide.
    typedef struct packed {
        addr_t inst_addr;
        inst_t inst;
    } if_id_t;

    function automatic addr_t next_seq_pc(input addr_t pc);
        return pc + addr_t'(ILEN_BYTES);
    endfunction

endpackage

// File: rtl/if_stage_inst_fifo.sv
// Small synchronous queue of fetched {inst_addr, inst} pairs.
// Head outputs read as zero whenever the queue is empty.
module inst_fifo
    import if_stage_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  if_id_t           push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output if_id_t           head_o,
    output logic [CNT_W-1:0] count_o
);

    if_id_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale slots are masked by the count.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, single-outstanding imem fetch FSM,
// and an instruction queue feeding decode over valid/ready.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_START,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_addr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if_state_e        state_q, state_d;
    addr_t            pc_q, pc_d;
    addr_t            req_pc_q, req_pc_d;
    logic             push;
    logic             has_room;
    logic [CNT_W-1:0] fifo_count;
    if_id_t           push_data;
    if_id_t           head;

    assign has_room  = fifo_count < CNT_W'(DEPTH);
    assign imem_req  = !rst && (state_q == IF_FETCH) && has_room;
    assign imem_addr = pc_q;
    assign push_data = '{inst_addr: req_pc_q, inst: imem_rdata};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        unique case (state_q)
            IF_FETCH: begin
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = IF_DROP;
                    end else begin
                        pc_d    = next_seq_pc(pc_q);
                        state_d = IF_WAIT;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid) begin
                    state_d = IF_FETCH;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        push = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = IF_DROP;
                end
            end
            IF_DROP: begin
                // The outstanding response belongs to a dead path.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_d = IF_FETCH;
                end
            end
            default: begin
                state_d = IF_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IF_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    inst_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (id_ready),
        .valid_o    (id_valid),
        .head_o     (head),
        .count_o    (fifo_count)
    );

    assign inst      = head.inst;
    assign inst_addr = head.inst_addr;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural imem responder with a scoreboard of
// expected decode-side pops, directed sequences and a redirect table.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .inst          (inst),
        .inst_addr     (inst_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [95:0] expq [$];
    logic [95:0] exp_e;

    int          lat       = 1;
    bit          gnt_en    = 1'b1;
    bit          stray_req = 1'b0;
    bit          ovr_en    = 1'b0;
    logic [31:0] ovr_data  = 32'h0;

    bit          pend, kill, rv_stray, g_fire, g_kill;
    logic [63:0] pend_addr, g_addr;
    int          remain;

    typedef struct {
        logic [63:0] rpc;
        logic        rdy;
        logic [63:0] exp_first;
        logic [63:0] exp_next;
    } vec_t;

    vec_t vt [4];

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a == 64'h8000_0000) begin
            return 32'h0000_0013;
        end
        return a[31:0] ^ 32'h1234_5673;
    endfunction

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int budget, input string name);
        int k = 0;
        while (!(imem_req && imem_gnt) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (!(imem_req && imem_gnt)) begin
            n_fail++;
            $display("FAIL %s: no grant within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (!id_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (!id_valid) begin
            n_fail++;
            $display("FAIL %s: no id_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: one response per grant after lat cycles; a response is
    // expected at decode only if no redirect/reset hit it while in flight.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        kill        = 1'b0;
        rv_stray    = 1'b0;
        remain      = 0;
        pend_addr   = '0;
        forever begin
            @(negedge clk);
            g_fire = imem_req && imem_gnt;
            g_addr = imem_addr;
            g_kill = redirect_valid || rst;
            if (pend) begin
                kill = kill || redirect_valid || rst;
            end
            if (imem_rvalid && !rv_stray && !kill) begin
                expq.push_back({pend_addr, imem_rdata});
            end
            @(posedge clk);
            #2;
            if (imem_rvalid) begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
                if (!rv_stray) begin
                    pend = 1'b0;
                end
                rv_stray = 1'b0;
            end
            if (g_fire) begin
                pend      = 1'b1;
                pend_addr = g_addr;
                kill      = g_kill;
                remain    = lat;
            end
            if (pend && remain > 0) begin
                remain--;
                if (remain == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ovr_en ? ovr_data : memf(pend_addr);
                end
            end
            if (stray_req && !imem_rvalid) begin
                imem_rvalid = 1'b1;
                rv_stray    = 1'b1;
                imem_rdata  = ovr_data;
            end
            imem_gnt = gnt_en && !pend;
        end
    end

    // Decode-side monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || redirect_valid) begin
                expq.delete();
            end else if (id_valid && id_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_pop: unexpected inst %h addr %h",
                             inst, inst_addr);
                end else begin
                    exp_e = expq.pop_front();
                    chk("sb_pop", {inst_addr, inst}, exp_e);
                end
            end
            if (!rst && !id_valid) begin
                chk("empty_head_zero", {inst_addr, inst}, 96'd0);
            end
        end
    end

    initial begin
        vt[0] = '{64'h0000_0000_0000_1000, 1'b1,
                  64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vt[2] = '{64'h8000_0000_0000_0000, 1'b1,
                  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0004};
        vt[3] = '{64'h0000_0000_8000_0FFC, 1'b0,
                  64'h0000_0000_8000_0FFC, 64'h0000_0000_8000_1000};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 96'(imem_req), 96'd0);
        chk("rst_addr", 96'(imem_addr), 96'h8000_0000);
        chk("rst_valid", 96'(id_valid), 96'd0);
        chk("rst_head", {inst_addr, inst}, 96'd0);

        // Reset release and first fetch.
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 96'(imem_req), 96'd1);
        chk("first_addr", 96'(imem_addr), 96'h8000_0000);
        repeat (2) @(negedge clk);
        chk("first_valid", 96'(id_valid), 96'd1);
        chk("first_inst", 96'(inst), 96'h13);
        chk("first_iaddr", 96'(inst_addr), 96'h8000_0000);
        chk("second_addr", 96'(imem_addr), 96'h8000_0004);

        // Backpressure fills the queue and stalls requests.
        step();
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0000;
        step();
        redirect_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_req", 96'(imem_req), 96'd0);
        chk("bp_addr", 96'(imem_addr), 96'h8000_0008);
        chk("bp_head", 96'(inst_addr), 96'h8000_0000);
        step();
        id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resume_req", 96'(imem_req), 96'd1);
        chk("bp_resume_addr", 96'(imem_addr), 96'h8000_0008);
        chk("bp_head2", 96'(inst_addr), 96'h8000_0004);

        // Redirect while waiting for a response.
        step();
        lat = 2;
        @(negedge clk);
        wait_grant(10, "wait_grant_t3");
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        ovr_en         = 1'b1;
        ovr_data       = 32'hDEAD_BEEF;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rw_addr", 96'(imem_addr), 96'h8000_1000);
        chk("rw_valid", 96'(id_valid), 96'd0);
        chk("rw_req_drop", 96'(imem_req), 96'd0);
        step();
        ovr_en = 1'b0;
        @(negedge clk);
        chk("rw_next_req", 96'(imem_req), 96'd1);
        chk("rw_next_addr", 96'(imem_addr), 96'h8000_1000);

        // Redirect on the same cycle as a grant.
        step();
        lat    = 1;
        gnt_en = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rg_req_idle", 96'(imem_req), 96'd1);
        step();
        gnt_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rg_addr", 96'(imem_addr), 96'h8000_2000);
        chk("rg_req_drop", 96'(imem_req), 96'd0);
        @(negedge clk);
        chk("rg_next_req", 96'(imem_req), 96'd1);
        chk("rg_next_addr", 96'(imem_addr), 96'h8000_2000);

        // Full queue hit by redirect, pop and a stray rvalid together.
        step();
        id_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_valid", 96'(id_valid), 96'd1);
        chk("full_req", 96'(imem_req), 96'd0);
        chk("full_head", 96'(inst_addr), 96'h8000_2000);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        id_ready       = 1'b1;
        stray_req      = 1'b1;
        ovr_data       = 32'hCAFE_0001;
        step();
        redirect_valid = 1'b0;
        stray_req      = 1'b0;
        @(negedge clk);
        chk("tri_valid", 96'(id_valid), 96'd0);
        chk("tri_req", 96'(imem_req), 96'd1);
        chk("tri_addr", 96'(imem_addr), 96'h8000_3000);

        // Reset pulsed while dropping, followed by a stray response.
        step();
        gnt_en = 1'b0;
        lat    = 3;
        repeat (6) @(posedge clk);
        #1;
        gnt_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4000;
        step();
        redirect_valid = 1'b0;
        rst            = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rd_addr", 96'(imem_addr), 96'h8000_0000);
        chk("rd_req", 96'(imem_req), 96'd1);
        chk("rd_valid", 96'(id_valid), 96'd0);
        repeat (2) @(negedge clk);
        chk("rd_stray_ignored", 96'(id_valid), 96'd0);
        wait_valid(20, "wait_valid_rd");
        chk("rd_clean_iaddr", 96'(inst_addr), 96'h8000_0000);
        chk("rd_clean_inst", 96'(inst), 96'h13);

        // Redirect table, including 64-bit PC wrap.
        step();
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            id_ready = vt[i].rdy;
            repeat (3) @(posedge clk);
            #1;
            redirect_valid = 1'b1;
            redirect_pc    = vt[i].rpc;
            step();
            redirect_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", 96'(id_valid), 96'd0);
            chk("tbl_addr", 96'(imem_addr), 96'(vt[i].exp_first));
            wait_grant(10, "tbl_grant");
            chk("tbl_gaddr", 96'(imem_addr), 96'(vt[i].exp_first));
            @(negedge clk);
            chk("tbl_next", 96'(imem_addr), 96'(vt[i].exp_next));
        end

        // Drain everything still owed to decode.
        step();
        id_ready = 1'b1;
        gnt_en   = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_drain", 96'(expq.size()), 96'd0);
        chk("drain_valid", 96'(id_valid), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
